vid_phy_controller_v2_2_20_gt_rx_tmdsclk_patchk: RTL and testbench
==================================================================

// Module: vid_phy_controller_v2_2_20_gt_rx_tmdsclk_patchk
// PURPOSE
//  Receive-side checker for the TMDS clock pattern sent over a GT channel by the TX pattern generator.
//  Scans RXDATA from one GT RX channel for square-wave runs of 5*N bits, N = 1..5.
//  Locks to the run length, reports the detected line-rate ratio code and counts pattern errors.
//  Sits between the GT RX user-data port and the controller status registers; lets firmware confirm
//  the TMDS clock pattern / ratio before using the channel as a reference clock.
// PARAMETERS
//  RXDATA_WIDTH  40  RX user-data width; legal values 40 or 20
//  LOCK_WORDS    4   consecutive good words required to lock (1..15)
//  UNLOCK_WORDS  4   consecutive bad words while locked that force loss of lock (1..15)
// PORTS
//  RXUSRCLK_IN     in   1        RX user clock; the only clock
//  RST_N_IN        in   1        async active-low reset
//  CTRL_EN_IN      in   1        checker enable; synchronous to RXUSRCLK_IN
//  CTRL_RATIO_IN   in   3        expected ratio code (1=10 .. 5=50); synchronous to RXUSRCLK_IN
//  RXDATA_IN       in   W        GT RX data; bit 0 is first on the line
//  LOCK_OUT        out  1        pattern locked
//  RATIO_OUT       out  3        detected ratio code N; 0 when not locked
//  MATCH_OUT       out  1        LOCK_OUT && RATIO_OUT==CTRL_RATIO_IN
//  ERR_CNT_OUT     out  16       bad words seen while locked; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset and outputs
//  - Reset: reset is asynchronous and active-low (RST_N_IN); one clock, RXUSRCLK_IN.
//  - All outputs and all state reset to 0 / IDLE.
//  - CTRL_EN_IN=0 synchronously forces the same values on the next edge.
//  Pipeline (3 cycles from RXDATA_IN sample to output)
//  - S0: register RXDATA_IN.
//  - S1: LSB-first scan of the word with the carried run-length counter crun (5b, saturates at 31).
//    Every transition closes a run of length crun+k. Registered results: nclosed; allsame; len = the common
//    closed length; stuck = (trailing run > 25).
//  - S2: FSM; outputs are registered.
//  Word classification (S2)
//  - bad: any closed run length not in {5,10,15,20,25}; or closed runs unequal; or len != tracked L; or stuck.
//  - good: nclosed>=1, all closed runs equal, length valid and == L.
//  - neutral: nclosed==0 and not stuck. Needed for 25-bit runs spanning 20-bit words.
//  FSM
//  - IDLE: enter on CTRL_EN_IN rising -> SEEK.
//  - SEEK: one word. Its closed runs are discarded (first run is partial); crun carries -> ACQ.
//  - ACQ, first valid word: sets L. good: acq_cnt++. neutral: hold. bad: acq_cnt=0, L cleared.
//    acq_cnt==LOCK_WORDS -> LOCKED; LOCK_OUT=1, RATIO_OUT=L/5.
//  - LOCKED, good: bad_cnt=0. neutral: hold.
//    bad: ERR_CNT_OUT++ (saturating), bad_cnt++.
//    bad_cnt==UNLOCK_WORDS -> ACQ; LOCK_OUT=0, RATIO_OUT=0, acq_cnt=0, L cleared. ERR_CNT_OUT held.
//  - Any state, CTRL_EN_IN=0 -> IDLE; ERR_CNT_OUT cleared.
//  Boundary conditions
//  - A constant-level word adds W to crun (saturating). Once crun>25, every word is bad until a transition.
//  - A run closed after saturation has length >=31 -> bad.
//  - Bit alignment is arbitrary; runs spanning word boundaries are measured via crun.
//  - W=20, N=5: alternating neutral/good words are legal.
//  - MATCH_OUT is combinational from registered LOCK_OUT/RATIO_OUT and CTRL_RATIO_IN.
//  - A CTRL_RATIO_IN change affects MATCH_OUT only; it never affects lock.
// TESTING
//  1. W=40, N=1, word 40'hF83E0F83E0 every cycle, CTRL_RATIO_IN=1.
//     -> LOCK_OUT=1, RATIO_OUT=1, MATCH_OUT=1 three cycles after the 5th word (SEEK + 4 good).
//  2. Same stream rotated left by 2 bits -> identical lock and RATIO_OUT=1.
//     With CTRL_RATIO_IN=2 -> MATCH_OUT=0.
//  3. W=40, N=5, 5-word cycle of the 25/25 pattern -> RATIO_OUT=5.
//     W=20, N=3 (15/15 pattern) -> RATIO_OUT=3.
//  4. Locked at N=2: flip bit 7 of one word -> ERR_CNT_OUT=1, LOCK_OUT stays 1.
//     Then 4 consecutive corrupted words -> ERR_CNT_OUT=5, LOCK_OUT=0, RATIO_OUT=0.
//     Clean data resumes -> relock after SEEK-free ACQ of 4 good words.
//  5. RXDATA_IN=0 constant after enable -> never locks, ERR_CNT_OUT=0.
//     A transition after saturation closes a >=31-bit run -> bad; ACQ restarts.
//  6. Locked, RST_N_IN pulsed low mid-word -> all outputs 0 immediately (async).
//     Locked, CTRL_EN_IN=0 one cycle -> outputs 0 on next edge; re-enable -> relock after SEEK+4.

Source files
------------

// File: rtl/vid_phy_controller_v2_2_20_gt_rx_tmdsclk_patchk.sv
// -----------------------------------------------------------------------------
// vid_phy_controller_v2_2_20_gt_rx_tmdsclk_patchk
//
// Receive-side checker for the TMDS clock pattern looped through a GT channel.
// The expected stream is a square wave whose half-period is 5*N bits, N = 1..5.
// The checker measures run lengths across word boundaries, locks onto a
// constant run length, reports the ratio code N and counts bad words while
// locked.
//
// Pipeline: S0 registers RXDATA_IN, S1 scans the word for run lengths,
// S2 classifies the word and runs the lock FSM. Outputs are registered in S2.
//
// Ports
//   RXUSRCLK_IN    RX user clock (only clock)
//   RST_N_IN       asynchronous active-low reset
//   CTRL_EN_IN     checker enable; low clears all state on the next edge
//   CTRL_RATIO_IN  expected ratio code, only used for MATCH_OUT
//   RXDATA_IN      GT RX data, bit 0 first on the line
//   LOCK_OUT       pattern locked
//   RATIO_OUT      detected ratio code, 0 while unlocked
//   MATCH_OUT      locked and detected ratio equals CTRL_RATIO_IN
//   ERR_CNT_OUT    saturating count of bad words seen while locked
// -----------------------------------------------------------------------------
module vid_phy_controller_v2_2_20_gt_rx_tmdsclk_patchk #(
    parameter int RXDATA_WIDTH = 40,
    parameter int LOCK_WORDS   = 4,
    parameter int UNLOCK_WORDS = 4
) (
    input  logic                    RXUSRCLK_IN,
    input  logic                    RST_N_IN,
    input  logic                    CTRL_EN_IN,
    input  logic [2:0]              CTRL_RATIO_IN,
    input  logic [RXDATA_WIDTH-1:0] RXDATA_IN,
    output logic                    LOCK_OUT,
    output logic [2:0]              RATIO_OUT,
    output logic                    MATCH_OUT,
    output logic [15:0]             ERR_CNT_OUT
);

    localparam int CW     = $clog2(RXDATA_WIDTH + 1);
    localparam int STAGES = 1;

    // Per-word scan result handed from S1 to S2
    typedef struct packed {
        logic [CW-1:0] nclosed;  // runs closed inside this word
        logic          allsame;  // all closed runs have the same length
        logic [4:0]    len;      // length of the first closed run
        logic          stuck;    // trailing run already longer than 25
    } scan_t;

    typedef enum logic [1:0] {IDLE, SEEK, ACQ, LOCKED} state_t;

    // vld_pipe[0]: rx_q holds a word; vld_pipe[1]: scan_q holds its scan
    logic [STAGES:0]         vld_pipe;
    logic [RXDATA_WIDTH-1:0] rx_q;
    logic [4:0]              crun;       // carried run length, 0 = no run yet
    logic                    last_bit;
    logic [4:0]              crun_c;
    logic                    last_bit_c;
    scan_t                   scan_c;
    scan_t                   scan_q;

    state_t     state;
    logic [4:0] l_len;                   // tracked run length, 0 = not set
    logic [3:0] acq_cnt;
    logic [3:0] bad_cnt;

    logic len_ok;
    logic has_run;
    logic w_bad;
    logic w_good;

    function automatic logic [2:0] ratio_of(input logic [4:0] len);
        case (len)
            5'd5:    ratio_of = 3'd1;
            5'd10:   ratio_of = 3'd2;
            5'd15:   ratio_of = 3'd3;
            5'd20:   ratio_of = 3'd4;
            5'd25:   ratio_of = 3'd5;
            default: ratio_of = 3'd0;
        endcase
    endfunction

    // ---------------- S1 combinational scan, LSB first ----------------
    always_comb begin : scan
        logic [4:0]    c;
        logic          lb;
        logic [CW-1:0] n;
        logic          same;
        logic [4:0]    flen;
        c    = crun;
        lb   = last_bit;
        n    = '0;
        same = 1'b1;
        flen = 5'd0;
        for (int i = 0; i < RXDATA_WIDTH; i++) begin
            // A transition closes the current run; with no run yet (c==0)
            // the first bit simply opens one.
            if (c != 5'd0 && rx_q[i] != lb) begin
                if (n == '0)
                    flen = c;
                else if (c != flen)
                    same = 1'b0;
                n = n + CW'(1);
                c = 5'd1;
            end else if (c != 5'd31) begin
                c = c + 5'd1;
            end
            lb = rx_q[i];
        end
        crun_c         = c;
        last_bit_c     = lb;
        scan_c.nclosed = n;
        scan_c.allsame = same;
        scan_c.len     = flen;
        scan_c.stuck   = (c > 5'd25);
    end

    // ---------------- S0 / S1 registers ----------------
    always_ff @(posedge RXUSRCLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            vld_pipe <= '0;
            rx_q     <= '0;
            crun     <= 5'd0;
            last_bit <= 1'b0;
            scan_q   <= '0;
        end else if (!CTRL_EN_IN) begin
            vld_pipe <= '0;
            rx_q     <= '0;
            crun     <= 5'd0;
            last_bit <= 1'b0;
            scan_q   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
            rx_q     <= RXDATA_IN;
            if (vld_pipe[0]) begin
                crun     <= crun_c;
                last_bit <= last_bit_c;
                scan_q   <= scan_c;
            end
        end
    end

    // ---------------- S2 word classification ----------------
    always_comb begin
        len_ok  = (scan_q.len == 5'd5)  || (scan_q.len == 5'd10) ||
                  (scan_q.len == 5'd15) || (scan_q.len == 5'd20) ||
                  (scan_q.len == 5'd25);
        has_run = (scan_q.nclosed != '0);
        w_bad   = scan_q.stuck ||
                  (has_run && (!scan_q.allsame || !len_ok ||
                               (l_len != 5'd0 && scan_q.len != l_len)));
        // Neither good nor bad: no run closed in this word (long runs
        // spanning narrow words).
        w_good  = has_run && !w_bad;
    end

    // ---------------- S2 lock FSM ----------------
    always_ff @(posedge RXUSRCLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            state       <= IDLE;
            l_len       <= 5'd0;
            acq_cnt     <= 4'd0;
            bad_cnt     <= 4'd0;
            LOCK_OUT    <= 1'b0;
            RATIO_OUT   <= 3'd0;
            ERR_CNT_OUT <= 16'd0;
        end else if (!CTRL_EN_IN) begin
            state       <= IDLE;
            l_len       <= 5'd0;
            acq_cnt     <= 4'd0;
            bad_cnt     <= 4'd0;
            LOCK_OUT    <= 1'b0;
            RATIO_OUT   <= 3'd0;
            ERR_CNT_OUT <= 16'd0;
        end else begin
            case (state)
                IDLE: state <= SEEK;
                // First scanned word starts mid-run; its closed runs are
                // dropped but crun keeps carrying.
                SEEK: if (vld_pipe[1]) state <= ACQ;
                ACQ: if (vld_pipe[1]) begin
                    if (w_bad) begin
                        acq_cnt <= 4'd0;
                        l_len   <= 5'd0;
                    end else if (w_good) begin
                        l_len <= scan_q.len;
                        if ({1'b0, acq_cnt} + 5'd1 == 5'(LOCK_WORDS)) begin
                            state     <= LOCKED;
                            LOCK_OUT  <= 1'b1;
                            RATIO_OUT <= ratio_of(scan_q.len);
                            acq_cnt   <= 4'd0;
                        end else begin
                            acq_cnt <= acq_cnt + 4'd1;
                        end
                    end
                end
                LOCKED: if (vld_pipe[1]) begin
                    if (w_good) begin
                        bad_cnt <= 4'd0;
                    end else if (w_bad) begin
                        if (ERR_CNT_OUT != 16'hFFFF)
                            ERR_CNT_OUT <= ERR_CNT_OUT + 16'd1;
                        if ({1'b0, bad_cnt} + 5'd1 == 5'(UNLOCK_WORDS)) begin
                            // Drop straight back to acquisition; run
                            // tracking stays aligned so no SEEK is needed.
                            state     <= ACQ;
                            LOCK_OUT  <= 1'b0;
                            RATIO_OUT <= 3'd0;
                            acq_cnt   <= 4'd0;
                            bad_cnt   <= 4'd0;
                            l_len     <= 5'd0;
                        end else begin
                            bad_cnt <= bad_cnt + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign MATCH_OUT = LOCK_OUT && (RATIO_OUT == CTRL_RATIO_IN);

endmodule

// File: tb/tb_vid_phy_controller_v2_2_20_gt_rx_tmdsclk_patchk.sv
// Bench: two checkers (40-bit and 20-bit words) fed from an ideal square-wave
// bit stream with optional bit corruption, compared against a run-length
// reference model delayed by the three-cycle pipeline.
module tb_vid_phy_controller_v2_2_20_gt_rx_tmdsclk_patchk;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [2:0]  ratio_in;
    logic [39:0] d0;
    logic [19:0] d1;
    logic        lock0, lock1, match0, match1;
    logic [2:0]  ratio0, ratio1;
    logic [15:0] err0, err1;

    always #5 clk = ~clk;

    vid_phy_controller_v2_2_20_gt_rx_tmdsclk_patchk #(.RXDATA_WIDTH(40)) u_dut40 (
        .RXUSRCLK_IN(clk), .RST_N_IN(rst_n), .CTRL_EN_IN(en), .CTRL_RATIO_IN(ratio_in),
        .RXDATA_IN(d0), .LOCK_OUT(lock0), .RATIO_OUT(ratio0), .MATCH_OUT(match0),
        .ERR_CNT_OUT(err0));

    vid_phy_controller_v2_2_20_gt_rx_tmdsclk_patchk #(.RXDATA_WIDTH(20)) u_dut20 (
        .RXUSRCLK_IN(clk), .RST_N_IN(rst_n), .CTRL_EN_IN(en), .CTRL_RATIO_IN(ratio_in),
        .RXDATA_IN(d1), .LOCK_OUT(lock1), .RATIO_OUT(ratio1), .MATCH_OUT(match1),
        .ERR_CNT_OUT(err1));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", tag, act, exp);
    endtask

    // ---------------- stream generator ----------------
    int      g_n;           // half-period is 5*g_n bits; 0 = constant low
    int      phase [2];
    longint  pos   [2];

    task automatic gen(input int i, input int wid, output logic [39:0] w);
        w = '0;
        for (int k = 0; k < wid; k++) begin
            if (g_n != 0)
                w[k] = (((pos[i] + longint'(phase[i])) / longint'(5 * g_n)) % 2) == 1;
            pos[i]++;
        end
    endtask

    task automatic set_stream(input int n, input int p0, input int p1);
        g_n = n; phase[0] = p0; phase[1] = p1; pos[0] = 0; pos[1] = 0;
    endtask

    // ---------------- reference model ----------------
    int m_run [2];
    bit m_bit [2];
    bit m_fresh [2];
    bit m_seek [2];
    int m_l [2];
    int m_acq [2];
    int m_badc [2];
    int m_err [2];
    bit m_lock [2];
    int h_lock [2][3];
    int h_ratio [2][3];
    int h_err [2][3];

    task automatic m_clear(input int i);
        m_run[i] = 0; m_bit[i] = 0; m_fresh[i] = 1; m_seek[i] = 1;
        m_l[i] = 0; m_acq[i] = 0; m_badc[i] = 0; m_err[i] = 0; m_lock[i] = 0;
        for (int j = 0; j < 3; j++) begin
            h_lock[i][j] = 0; h_ratio[i][j] = 0; h_err[i][j] = 0;
        end
    endtask

    task automatic m_word(input int i, input logic [39:0] w, input int wid);
        int runs[$];
        bit bad;
        bit good;
        bit b;
        for (int k = 0; k < wid; k++) begin
            b = w[k];
            if (m_fresh[i]) begin
                m_fresh[i] = 0; m_run[i] = 1;
            end else if (b != m_bit[i]) begin
                runs.push_back(m_run[i]); m_run[i] = 1;
            end else begin
                m_run[i]++;
            end
            m_bit[i] = b;
        end
        if (m_seek[i]) begin
            m_seek[i] = 0;
            return;
        end
        bad = (m_run[i] > 25);
        foreach (runs[j])
            if (runs[j] % 5 != 0 || runs[j] > 25 || runs[j] != runs[0] ||
                (m_l[i] != 0 && runs[j] != m_l[i])) bad = 1;
        good = !bad && runs.size() > 0;
        if (!m_lock[i]) begin
            if (bad) begin
                m_acq[i] = 0; m_l[i] = 0;
            end else if (good) begin
                m_l[i] = runs[0];
                m_acq[i]++;
                if (m_acq[i] == 4) m_lock[i] = 1;
            end
        end else begin
            if (good) m_badc[i] = 0;
            else if (bad) begin
                if (m_err[i] < 65535) m_err[i]++;
                m_badc[i]++;
                if (m_badc[i] == 4) begin
                    m_lock[i] = 0; m_acq[i] = 0; m_l[i] = 0; m_badc[i] = 0;
                end
            end
        end
    endtask

    task automatic m_push(input int i);
        for (int j = 2; j > 0; j--) begin
            h_lock[i][j] = h_lock[i][j-1]; h_ratio[i][j] = h_ratio[i][j-1];
            h_err[i][j] = h_err[i][j-1];
        end
        h_lock[i][0]  = m_lock[i];
        h_ratio[i][0] = m_lock[i] ? m_l[i] / 5 : 0;
        h_err[i][0]   = m_err[i];
    endtask

    task automatic do_checks();
        int el;
        int er;
        for (int i = 0; i < 2; i++) begin
            el = h_lock[i][2]; er = h_ratio[i][2];
            chk($sformatf("lock%0d", i),  (i == 0) ? int'(lock0)  : int'(lock1),  el);
            chk($sformatf("ratio%0d", i), (i == 0) ? int'(ratio0) : int'(ratio1), er);
            chk($sformatf("match%0d", i), (i == 0) ? int'(match0) : int'(match1),
                (el == 1 && er == int'(ratio_in)) ? 1 : 0);
            chk($sformatf("err%0d", i),   (i == 0) ? int'(err0)   : int'(err1),   h_err[i][2]);
        end
    endtask

    task automatic step(input bit e, input logic [39:0] k0, input logic [39:0] k1);
        logic [39:0] w;
        @(negedge clk);
        en = e;
        gen(0, 40, w); d0 = w ^ k0;
        gen(1, 20, w); d1 = w[19:0] ^ k1[19:0];
        @(posedge clk);
        if (!e) begin
            m_clear(0); m_clear(1);
        end else begin
            m_word(0, d0, 40); m_word(1, {20'd0, d1}, 20);
            m_push(0); m_push(1);
        end
        #1 do_checks();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b1, '0, '0);
    endtask

    logic [39:0] one40;
    logic [39:0] bit7;
    logic [39:0] mk0, mk1;

    initial begin
        one40 = 40'd1;
        bit7  = one40 << 7;
        rst_n = 1'b0; en = 1'b0; ratio_in = 3'd1; d0 = '0; d1 = '0;
        set_stream(1, 0, 0);
        m_clear(0); m_clear(1);
        repeat (3) @(negedge clk);
        do_checks();                           // reset state
        rst_n = 1'b1;

        // N=1, phase 0: 40-bit words are 40'hF83E0F83E0
        step(1'b0, '0, '0); set_stream(1, 0, 0); ratio_in = 3'd1;
        run(10);
        // rotated left by 2 bits, then a mismatching expected ratio
        step(1'b0, '0, '0); set_stream(1, 8, 8);
        run(10);
        ratio_in = 3'd2; run(3);
        // N=5 and N=3, arbitrary alignment
        step(1'b0, '0, '0); set_stream(5, 7, 13); ratio_in = 3'd5; run(15);
        step(1'b0, '0, '0); set_stream(3, 4, 11); ratio_in = 3'd3; run(12);
        // N=2: one corrupted word, then four in a row, then relock
        step(1'b0, '0, '0); set_stream(2, 3, 3); ratio_in = 3'd2; run(10);
        step(1'b1, bit7, bit7); run(3);
        for (int k = 0; k < 4; k++) step(1'b1, bit7, bit7);
        run(10);
        // constant low, then a transition after saturation
        step(1'b0, '0, '0); set_stream(0, 0, 0); run(8);
        g_n = 1; run(10);
        // async reset mid-word while locked
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("arst_lock0", int'(lock0), 0); chk("arst_ratio0", int'(ratio0), 0);
        chk("arst_err1", int'(err1), 0);   chk("arst_lock1", int'(lock1), 0);
        m_clear(0); m_clear(1);
        #1 rst_n = 1'b1;
        run(8);
        // enable dropped for one cycle while locked
        step(1'b0, '0, '0); run(8);

        // randomized episodes
        for (int ep = 0; ep < 30; ep++) begin
            step(1'b0, '0, '0);
            set_stream(int'($urandom_range(5, 1)), int'($urandom_range(49, 0)),
                       int'($urandom_range(49, 0)));
            ratio_in = 3'($urandom_range(7, 0));
            for (int k = 0; k < int'($urandom_range(20, 8)); k++) begin
                mk0 = ($urandom_range(7, 0) == 0) ? (one40 << $urandom_range(39, 0)) : '0;
                mk1 = ($urandom_range(7, 0) == 0) ? (one40 << $urandom_range(19, 0)) : '0;
                step(($urandom_range(39, 0) != 0), mk0, mk1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
